// File: rtl/regfile_pkg.sv
// Shared types for the register-file writeback path: widths, register index and writeback request.
// Used by the arbiter top and by benches that drive it.
package regfile_pkg;

  localparam int XLEN      = 32;
  localparam int NREGS     = 32;
  localparam int REG_IDX_W = 5;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef struct packed {
    reg_idx_t        rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

  function automatic logic [NREGS-1:0] reg_onehot(input reg_idx_t idx);
    logic [NREGS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant, combinational within the cycle; the pointer flips only on a contended grant.
// Both grants are held low while rst is high, so no request can transfer during reset.
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic i_req0,
  input  logic i_req1,
  output logic o_gnt0,
  output logic o_gnt1
);

  logic r_rr;
  logic w_contend;

  assign w_contend = i_req0 & i_req1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr <= 1'b0;
    end else if (w_contend) begin
      r_rr <= ~r_rr;
    end
  end

  always_comb begin
    o_gnt0 = ~rst & i_req0 & (~i_req1 | ~r_rr);
    o_gnt1 = ~rst & i_req1 & (~i_req0 | r_rr);
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the regfile write port between ALU (src0) and load unit (src1); write lands one cycle after accept,
// readys are the round-robin grants. Tracks per-register pending bits for RAW stalls and a halt drain; WB_BYPASS_EN adds forwarding.
module regfile_wb_arbiter
  import regfile_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s0_valid,
  output logic                 s0_ready,
  input  logic [REG_IDX_W-1:0] s0_rd,
  input  logic [XLEN-1:0]      s0_data,
  input  logic                 s1_valid,
  output logic                 s1_ready,
  input  logic [REG_IDX_W-1:0] s1_rd,
  input  logic [XLEN-1:0]      s1_data,
  input  logic                 issue_valid,
  input  logic [REG_IDX_W-1:0] issue_rd,
  input  logic [REG_IDX_W-1:0] rs1_num,
  input  logic [REG_IDX_W-1:0] rs2_num,
  output logic                 hazard,
`ifdef WB_BYPASS_EN
  output logic                 rs1_fwd_valid,
  output logic [XLEN-1:0]      rs1_fwd_data,
  output logic                 rs2_fwd_valid,
  output logic [XLEN-1:0]      rs2_fwd_data,
`endif
  input  logic                 halted,
  output logic                 drained,
  output logic [REG_IDX_W-1:0] rd_num,
  output logic [XLEN-1:0]      rd_data,
  output logic                 rd_we
);

  wb_req_t          w_s0_req;
  wb_req_t          w_s1_req;
  wb_req_t          w_sel_req;
  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_fire;
  logic             w_issue_set;
  logic [NREGS-1:0] w_set;
  logic [NREGS-1:0] w_clr;
  logic [NREGS-1:0] w_pending_nxt;
  logic             w_drain_cond;
  logic             w_rs1_pend;
  logic             w_rs2_pend;

  logic             r_rd_we;
  reg_idx_t         r_rd_num;
  logic [XLEN-1:0]  r_rd_data;
  logic [NREGS-1:0] r_pending;
  logic             r_drained;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .i_req0 (s0_valid),
    .i_req1 (s1_valid),
    .o_gnt0 (w_gnt0),
    .o_gnt1 (w_gnt1)
  );

  always_comb begin
    w_s0_req.rd   = s0_rd;
    w_s0_req.data = s0_data;
    w_s1_req.rd   = s1_rd;
    w_s1_req.data = s1_data;
    w_sel_req     = w_gnt1 ? w_s1_req : w_s0_req;
  end

  assign w_fire   = w_gnt0 | w_gnt1;
  assign s0_ready = w_gnt0;
  assign s1_ready = w_gnt1;

  // Issue during halt is dropped so the drain cannot be extended by new producers.
  assign w_issue_set = issue_valid & ~halted & (issue_rd != '0);
  assign w_set       = w_issue_set ? reg_onehot(issue_rd) : '0;
  assign w_clr       = r_rd_we ? reg_onehot(r_rd_num) : '0;

  always_comb begin
    w_pending_nxt    = (r_pending & ~w_clr) | w_set;
    w_pending_nxt[0] = 1'b0;
  end

  assign w_drain_cond = halted & (r_pending == '0) & ~r_rd_we & ~s0_valid & ~s1_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_we   <= 1'b0;
      r_rd_num  <= '0;
      r_rd_data <= '0;
      r_pending <= '0;
      r_drained <= 1'b0;
    end else begin
      r_rd_we <= w_fire & (w_sel_req.rd != '0);
      if (w_fire) begin
        r_rd_num  <= w_sel_req.rd;
        r_rd_data <= w_sel_req.data;
      end
      r_pending <= w_pending_nxt;
      r_drained <= halted & (r_drained | w_drain_cond);
    end
  end

  assign rd_we   = r_rd_we;
  assign rd_num  = r_rd_num;
  assign rd_data = r_rd_data;
  assign drained = r_drained;

  assign w_rs1_pend = (rs1_num != '0) & r_pending[rs1_num];
  assign w_rs2_pend = (rs2_num != '0) & r_pending[rs2_num];

`ifdef WB_BYPASS_EN
  logic w_rs1_mask;
  logic w_rs2_mask;

  assign rs1_fwd_valid = r_rd_we & (r_rd_num == rs1_num) & (rs1_num != '0);
  assign rs2_fwd_valid = r_rd_we & (r_rd_num == rs2_num) & (rs2_num != '0);
  assign rs1_fwd_data  = r_rd_data;
  assign rs2_fwd_data  = r_rd_data;

  // A same-cycle re-issue means a newer producer is outstanding, so the forward cannot satisfy it.
  assign w_rs1_mask = rs1_fwd_valid & ~w_set[rs1_num];
  assign w_rs2_mask = rs2_fwd_valid & ~w_set[rs2_num];
  assign hazard     = (w_rs1_pend & ~w_rs1_mask) | (w_rs2_pend & ~w_rs2_mask);
`else
  assign hazard = w_rs1_pend | w_rs2_pend;
`endif

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (rd_num/rd_data/rd_we) between two writeback requesters: src0 = ALU/execute, src1 = load/memory unit.
- Round-robin arbitration with a valid/ready handshake per source. Output write is registered.
- Holds a per-register pending scoreboard, so the decode stage can stall on RAW hazards against rs1/rs2.
- Supports a halt drain, so the regfile dump only happens after all outstanding writes have landed.

Parameters:
- XLEN, 32, data width of rd_data.
- NREGS, 32, number of architectural registers (scoreboard depth). Register index width is 5.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- s0_valid  in  1  src0 write request
- s0_ready  out  1  src0 request accepted this cycle
- s0_rd  in  5  src0 destination register
- s0_data  in  XLEN  src0 write data
- s1_valid  in  1  src1 write request
- s1_ready  out  1  src1 request accepted this cycle
- s1_rd  in  5  src1 destination register
- s1_data  in  XLEN  src1 write data
- issue_valid  in  1  decode issued an instruction that will write issue_rd
- issue_rd  in  5  destination of the issued instruction
- rs1_num  in  5  decode source register 1
- rs2_num  in  5  decode source register 2
- hazard  out  1  rs1 or rs2 is pending (nonzero register only)
- halted  in  1  core halt request
- drained  out  1  halted, no pending bits, no write in flight
- rd_num  out  5  to regfile
- rd_data  out  XLEN  to regfile
- rd_we  out  1  to regfile

Behaviour:
- Reset (rst high at a clk edge):
  - rd_we=0, rd_num=0, rd_data=0.
  - pending=0; round-robin pointer rr=0 (src0 favoured first).
  - drained=0; all readys 0 during reset.
- Arbitration is combinational within the cycle.
  - If exactly one source is valid, it is granted.
  - If both are valid, the source selected by rr is granted. rr then flips to the other source.
  - rr changes only on a contended grant.
- Readys:
  - sX_ready = grant to X.
  - A transfer happens when valid & ready.
  - A source must hold valid, rd and data stable until ready.
- Latency: an accepted request drives rd_num/rd_data/rd_we=1 on the next cycle, for exactly one cycle.
  - One write per cycle; throughput is 1/cycle.
- x0 writes:
  - An accepted request with rd=0 still handshakes (ready=1).
  - It produces rd_we=0 on the following cycle.
- Scoreboard pending[NREGS-1:0]:
  - Set: issue_valid with issue_rd!=0 sets pending[issue_rd] at the edge.
  - Clear: a registered write with rd_we=1 clears pending[rd_num] at the edge.
  - Set and clear of the same register in one cycle: set wins (the newer producer is outstanding).
  - pending[0] is never set.
- hazard = (rs1_num!=0 & pending[rs1_num]) | (rs2_num!=0 & pending[rs2_num]). It is combinational.
- Halt:
  - While halted=1, issue_valid is ignored (no new pending bits).
  - Grants continue, so outstanding writes drain.
  - drained is registered: 1 the cycle after halted=1 & pending==0 & rd_we==0 & !s0_valid & !s1_valid. It stays 1 while halted remains high.
  - halted falling clears drained next cycle.
- Reset mid-operation: an in-flight write is discarded (rd_we=0 next cycle). All pending bits are cleared.

Optional Feature:
- Macro: WB_BYPASS_EN.
- When defined, adds outputs rs1_fwd_valid, rs1_fwd_data, rs2_fwd_valid and rs2_fwd_data.
  - rsX_fwd_valid = rd_we & rd_num==rsX_num & rsX_num!=0; rsX_fwd_data = rd_data.
  - hazard masks a source register that is being forwarded this cycle, unless that register is also set by issue in the same cycle.
- When undefined, none of these ports exist. A write that is being committed still raises hazard until its pending bit clears, which costs decode one extra stall cycle.

Decomposition:
- Shared package regfile_pkg holds:
  - constants XLEN, NREGS, REG_IDX_W=5;
  - typedef reg_idx_t (5 bits);
  - typedef struct wb_req_t {rd, data}.
- One sub-module, rr_arb2: a 2-way round-robin grant plus pointer register. The scoreboard stays inline.

Test Plan:
- Single source: s0 writes x5=0x1234 -> s0_ready same cycle; next cycle rd_we=1, rd_num=5, rd_data=0x1234.
- Contention: both valid for 4 cycles (s0 x1..x4, s1 x11..x14) -> write order x1, x11, x2, x12, and so on; no cycle with two writes.
- Scoreboard: issue x7, then rs1_num=7 -> hazard=1 until the cycle after the x7 write commits, then hazard=0. In the same cycle as the commit, a re-issue of x7 keeps hazard=1.
- x0: write x0=0xFFFFFFFF -> handshake completes, rd_we stays 0. Issue x0 -> pending unchanged, hazard=0 for rs1_num=0.
- Halt drain: pending x3 and x9, halted=1 -> drained=0 until both writes commit. drained=1 one cycle later; issue_valid during the halt sets no bit.
- Reset mid-write: rst during an accepted request -> rd_we=0 next cycle, pending=0, rr=0. With WB_BYPASS_EN defined, the forward of x5 in its commit cycle gives rs1_fwd_valid=1 and hazard=0.
